video_interface_sys_pio_leds_blink: RTL and testbench
=====================================================

VIDEO_INTERFACE_SYS_PIO_LEDS_BLINK -- requirements
Module: video_interface_sys_pio_leds_blink

Interface
REQ-001 Parameter WIDTH, default 8, output channel count; legal 1..32.
REQ-002 Parameter RESET_VALUE, default 170, DATA reset value; bits [WIDTH-1:0] used.
REQ-003 Parameter PRESCALE_W, default 24, blink counter/period width; legal 1..32.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address  input  3  Avalon-MM slave word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  read data, zero-extended.
REQ-011 out_port  output  WIDTH  LED drive.

Function
REQ-012 Write strobe = chipselect & ~write_n; zero wait states; write takes effect at the next rising edge.
REQ-013 Read is combinational from address: readdata valid in the same cycle, read latency 0, no side effects.
REQ-014 Addr 0 DATA: R/W; write loads writedata[WIDTH-1:0].
REQ-015 Addr 1 SET: write ORs writedata[WIDTH-1:0] into DATA; read returns DATA.
REQ-016 Addr 2 CLEAR: write clears DATA bits where writedata=1; read returns DATA.
REQ-017 Addr 3 TOGGLE: write XORs writedata[WIDTH-1:0] into DATA; read returns DATA.
REQ-018 Addr 4 BLINK_MASK: R/W, WIDTH bits; 1 = channel blinks.
REQ-019 Addr 5 BLINK_PERIOD: R/W, PRESCALE_W bits from writedata[PRESCALE_W-1:0].
REQ-020 Addr 6 STATUS: read-only; bit 0 = phase, bits [PRESCALE_W:1] = counter, truncated to 31 bits; writes ignored.
REQ-021 Addr 7: reads 0, writes ignored.
REQ-022 Counter increments each cycle; when counter == BLINK_PERIOD, counter <= 0 and phase inverts; half-period = BLINK_PERIOD+1 cycles.
REQ-023 BLINK_PERIOD = 0: phase inverts every cycle.
REQ-024 Write to BLINK_PERIOD clears counter to 0 and suppresses a phase toggle in that cycle; phase otherwise holds.
REQ-025 Counter never exceeds BLINK_PERIOD; if it is above the period, the next cycle wraps it to 0 with a phase toggle.
REQ-026 out_port[i] = DATA[i] & (~BLINK_MASK[i] | phase), registered; it reflects register state one cycle after the state changes.
REQ-027 Writedata bits above WIDTH or PRESCALE_W are ignored; unused readdata bits read 0.

Reset
REQ-028 While reset=1 at a clock edge: DATA=RESET_VALUE, BLINK_MASK=0, BLINK_PERIOD=all ones, counter=0, phase=1.
REQ-029 Writes in a reset cycle are discarded; reset overrides any operation in flight.
REQ-030 out_port = RESET_VALUE[WIDTH-1:0] from the first edge after reset is asserted; readdata is combinational from reset state.

Configuration
REQ-031 Macro PIO_LEDS_BLINK_EN defined: blink counter, phase, BLINK_MASK, BLINK_PERIOD and STATUS are implemented as above.
REQ-032 PIO_LEDS_BLINK_EN undefined: no counter logic; addrs 4-6 read 0 and ignore writes; out_port = DATA, registered; addrs 0-3 unchanged.

Verification
REQ-033 Reset with WIDTH=8 -> out_port=0xAA; readdata at addr 0 = 0x000000AA; STATUS = 0x00000001.
REQ-034 Write DATA=0x0F, then SET 0x30, CLEAR 0x03, TOGGLE 0x81 -> DATA reads 0x0F, 0x3F, 0x3C, 0xBD.
REQ-035 DATA=0xFF, MASK=0x01, PERIOD=3 -> out_port bit 0 alternates every 4 cycles; bits 7:1 stay 1.
REQ-036 PERIOD=0, MASK=0xFF, DATA=0xFF -> out_port toggles between 0xFF and 0x00 every cycle.
REQ-037 PERIOD write in the same cycle as the terminal count -> counter reads 0 next cycle; phase is unchanged.
REQ-038 Build without PIO_LEDS_BLINK_EN; write 0x55 to addr 4 -> addr 4 reads 0; out_port equals DATA.

Source files
------------

// File: rtl/video_interface_sys_pio_leds_blink.sv
// video_interface_sys_pio_leds_blink: Avalon-MM LED PIO with set/clear/toggle and per-channel blink.
// Define PIO_LEDS_BLINK_EN to build the blink counter, phase, mask, period and status registers.
module video_interface_sys_pio_leds_blink #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd170,
    parameter int          PRESCALE_W  = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    logic             wr;
    logic             unused_wd;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] led;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    assign data_next = !wr              ? data :
                       address == 3'd0  ? wd :
                       address == 3'd1  ? data | wd :
                       address == 3'd2  ? data & ~wd :
                       address == 3'd3  ? data ^ wd : data;

    always_ff @(posedge clk) begin
        if (reset) begin
            data     <= RESET_VALUE[WIDTH-1:0];
            out_port <= RESET_VALUE[WIDTH-1:0];
        end else begin
            data     <= data_next;
            out_port <= led;
        end
    end

`ifdef PIO_LEDS_BLINK_EN
    logic [WIDTH-1:0]      mask;
    logic [PRESCALE_W-1:0] period;
    logic [PRESCALE_W-1:0] count;
    logic                  phase;
    logic [31:0]           status;

    // A period write restarts the half-period without flipping phase; >= also recovers an out-of-range count.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask   <= '0;
            period <= '1;
            count  <= '0;
            phase  <= 1'b1;
        end else begin
            if (wr && address == 3'd4)
                mask <= wd;
            if (wr && address == 3'd5) begin
                period <= writedata[PRESCALE_W-1:0];
                count  <= '0;
            end else if (count >= period) begin
                count <= '0;
                phase <= ~phase;
            end else begin
                count <= count + PRESCALE_W'(1);
            end
        end
    end

    assign status   = 32'({count, phase});
    assign led      = data & (~mask | {WIDTH{phase}});
    assign readdata = !address[2]      ? 32'(data) :
                      address == 3'd4  ? 32'(mask) :
                      address == 3'd5  ? 32'(period) :
                      address == 3'd6  ? status : 32'd0;
`else
    assign led      = data;
    assign readdata = !address[2] ? 32'(data) : 32'd0;
`endif
endmodule

// File: tb/tb_video_interface_sys_pio_leds_blink.sv
// tb_video_interface_sys_pio_leds_blink: directed and random bus traffic against a cycle-count blink model.
// Blink expectations are compiled in only when PIO_LEDS_BLINK_EN is defined, matching the DUT build.
module tb_video_interface_sys_pio_leds_blink;
    localparam int W  = 8;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;

    always #5 clk = ~clk;

    video_interface_sys_pio_leds_blink #(
        .WIDTH(W), .RESET_VALUE(32'd170), .PRESCALE_W(PW)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    int vectors = 0;
    int miscompares = 0;

    // Blink state is derived from edges elapsed since the last anchor (reset or period write).
    logic [W-1:0] m_data, m_mask, m_out;
    longint       m_period, m_n;
    logic         m_ph0;
    logic         ph;

    function automatic logic [PW-1:0] m_cnt();
        return PW'(m_n % (m_period + 1));
    endfunction

    function automatic logic m_phase();
        return m_ph0 ^ ((m_n / (m_period + 1)) % 2 == 1);
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (a < 3'd4) r = 32'(m_data);
`ifdef PIO_LEDS_BLINK_EN
        else if (a == 3'd4) r = 32'(m_mask);
        else if (a == 3'd5) r = 32'(m_period);
        else if (a == 3'd6) r = 32'(m_cnt()) * 2 + 32'(m_phase());
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'($urandom_range(0, 7));
        writedata  = $urandom;
        @(posedge clk);
        #1;
        m_data   = 8'hAA;
        m_mask   = '0;
        m_period = (64'd1 << PW) - 1;
        m_n      = 0;
        m_ph0    = 1'b1;
        m_out    = 8'hAA;
        check("reset_out", 32'(out_port), 32'(m_out));
    endtask

    task automatic cycle(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
        logic         wr;
        logic         p;
        logic [W-1:0] nxt;
        wr         = cs & ~wn;
        reset      = 1'b0;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        #1;
        check($sformatf("read_a%0d", a), readdata, model_read(a));
        p   = m_phase();
        nxt = m_data & (~m_mask | {W{p}});
        if (wr) begin
            case (a)
                3'd0: m_data = d[W-1:0];
                3'd1: m_data = m_data | d[W-1:0];
                3'd2: m_data = m_data & ~d[W-1:0];
                3'd3: m_data = m_data ^ d[W-1:0];
`ifdef PIO_LEDS_BLINK_EN
                3'd4: m_mask = d[W-1:0];
`endif
                default: ;
            endcase
        end
`ifdef PIO_LEDS_BLINK_EN
        if (wr && a == 3'd5) begin
            m_period = longint'(d[PW-1:0]);
            m_n      = 0;
            m_ph0    = p;
        end else begin
            m_n++;
        end
`else
        m_n++;
`endif
        m_out = nxt;
        @(posedge clk);
        #1;
        check($sformatf("out_a%0d", a), 32'(out_port), 32'(m_out));
    endtask

    initial begin
        do_reset();
        do_reset();
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        #1;
        check("rst_data", readdata, 32'h0000_00AA);
        address = 3'd6;
        #1;
`ifdef PIO_LEDS_BLINK_EN
        check("rst_status", readdata, 32'h0000_0001);
`else
        check("rst_status", readdata, 32'h0000_0000);
`endif
        check("rst_out", 32'(out_port), 32'h0000_00AA);

        cycle(1'b1, 1'b0, 3'd0, 32'hFFFF_FF0F);
        cycle(1'b0, 1'b1, 3'd0, 32'h0);
        cycle(1'b1, 1'b0, 3'd1, 32'h0000_0030);
        cycle(1'b0, 1'b1, 3'd1, 32'h0);
        cycle(1'b1, 1'b0, 3'd2, 32'h0000_0003);
        cycle(1'b0, 1'b1, 3'd2, 32'h0);
        cycle(1'b1, 1'b0, 3'd3, 32'h0000_0081);
        cycle(1'b0, 1'b1, 3'd3, 32'h0);
        check("data_bd", readdata, 32'h0000_00BD);
        cycle(1'b0, 1'b0, 3'd0, 32'h0000_0011);

        cycle(1'b1, 1'b0, 3'd0, 32'h0000_00FF);
        cycle(1'b1, 1'b0, 3'd4, 32'h0000_0001);
        cycle(1'b1, 1'b0, 3'd5, 32'h0000_0003);
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b1, 3'(i % 8), 32'h0);

        cycle(1'b1, 1'b0, 3'd5, 32'h0000_0000);
        cycle(1'b1, 1'b0, 3'd4, 32'h0000_00FF);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 3'd6, 32'h0);

`ifdef PIO_LEDS_BLINK_EN
        cycle(1'b1, 1'b0, 3'd5, 32'h0000_0003);
        for (int i = 0; i < 8 && m_cnt() != 3; i++) cycle(1'b0, 1'b1, 3'd6, 32'h0);
        ph = m_phase();
        cycle(1'b1, 1'b0, 3'd5, 32'h0000_0007);
        address = 3'd6;
        #1;
        check("period_at_tc", readdata, 32'(ph));
`endif

        cycle(1'b1, 1'b0, 3'd4, 32'h0000_0055);
        cycle(1'b0, 1'b1, 3'd4, 32'h0);
        cycle(1'b1, 1'b0, 3'd6, 32'hFFFF_FFFF);
        cycle(1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b1, 3'd7, 32'h0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                do_reset();
            end else begin
                logic [2:0]  a;
                logic [31:0] d;
                a = 3'($urandom_range(0, 7));
                d = (a == 3'd5 && $urandom_range(0, 9) != 0) ? 32'($urandom_range(0, 6)) : $urandom;
                cycle($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, a, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
